// File: rtl/dmem_responder.sv
// Word-organised data memory with byte-lane writes, programmable wait states and ready/stall.
// Define DMEM_ERR_EN to add err_o and the out-of-range / empty-select access checks.
module dmem_responder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned WAIT_CYC  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_ce_i,
  input  logic        ram_we_i,
  input  logic [31:0] ram_addr_i,
  input  logic [3:0]  ram_sel_i,
  input  logic [31:0] ram_data_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        stall_o
`ifdef DMEM_ERR_EN
  ,
  output logic        err_o
`endif
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   word_q;
  logic [3:0]          sel_q;
  logic [31:0]         wdata_q;
  logic                err_q;
  logic                ready_q;
  logic [31:0]         rdata_q;

  logic [31:0]         mem [Depth];

  logic [31:0]         off;
  logic [ADDR_W-1:0]   in_word;
  logic                in_err;
  logic                unused_off;

  assign off        = ram_addr_i - BASE_ADDR;
  assign in_word    = off[ADDR_W+1:2];
  assign unused_off = ^{off[31:ADDR_W+2], off[1:0]};

`ifdef DMEM_ERR_EN
  assign in_err = ((off >> (ADDR_W + 2)) != 32'd0) || (ram_sel_i == 4'h0);
`else
  assign in_err = 1'b0;
`endif

  // With zero wait states the access happens on the accepting edge using live inputs;
  // otherwise it happens at the end of WAIT using the captured request.
  logic              acc_fire;
  logic              use_live;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_word;
  logic [3:0]        acc_sel;
  logic [31:0]       acc_wdata;
  logic              acc_err;
  logic [31:0]       acc_mask;
  logic              mem_we;

  assign use_live  = (state_q == StIdle);
  assign acc_fire  = (use_live && ram_ce_i && (WAIT_CYC == 0)) ||
                     ((state_q == StWait) && ram_ce_i && (cnt_q == 4'd0));
  assign acc_we    = use_live ? ram_we_i   : we_q;
  assign acc_word  = use_live ? in_word    : word_q;
  assign acc_sel   = use_live ? ram_sel_i  : sel_q;
  assign acc_wdata = use_live ? ram_data_i : wdata_q;
  assign acc_err   = use_live ? in_err     : err_q;
  assign acc_mask  = {{8{acc_sel[3]}}, {8{acc_sel[2]}}, {8{acc_sel[1]}}, {8{acc_sel[0]}}};
  // Gated by rst so a zero-wait request held during reset cannot write.
  assign mem_we    = acc_fire && acc_we && !acc_err && rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int n = 0; n < 4; n++) begin
        if (acc_sel[n]) mem[acc_word][8*n +: 8] <= acc_wdata[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      word_q  <= '0;
      sel_q   <= 4'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      ready_q <= 1'b0;
      if (acc_fire) begin
        ready_q <= 1'b1;
        if (acc_err) begin
          rdata_q <= 32'h0;
        end else if (!acc_we) begin
          rdata_q <= mem[acc_word] & acc_mask;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (ram_ce_i) begin
            if (WAIT_CYC == 0) begin
              state_q <= StDone;
            end else begin
              state_q <= StWait;
              cnt_q   <= 4'(WAIT_CYC - 1);
              we_q    <= ram_we_i;
              word_q  <= in_word;
              sel_q   <= ram_sel_i;
              wdata_q <= ram_data_i;
              err_q   <= in_err;
            end
          end
        end
        StWait: begin
          if (!ram_ce_i) begin
            state_q <= StIdle;
          end else if (cnt_q == 4'd0) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DMEM_ERR_EN
  logic err_pulse_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= acc_fire && acc_err;
    end
  end

  assign err_o = err_pulse_q;
`endif

  assign data_o  = rdata_q;
  assign ready_o = ready_q;
  assign stall_o = ram_ce_i & ~ready_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: instance a (ADDR_W=10, WAIT_CYC=1) and instance b (ADDR_W=4, WAIT_CYC=0).
module tb_dmem_responder;

  logic clk;
  logic rst;

  logic        a_ce, a_we, a_ready, a_stall, a_err;
  logic [31:0] a_addr, a_wdata, a_data;
  logic [3:0]  a_sel;
  logic        b_ce, b_we, b_ready, b_stall, b_err;
  logic [31:0] b_addr, b_wdata, b_data;
  logic [3:0]  b_sel;

  int errors = 0;
  int checks = 0;

  dmem_responder #(.ADDR_W(10), .WAIT_CYC(1), .BASE_ADDR(32'h0)) u_a (
    .clk        (clk),
    .rst        (rst),
    .ram_ce_i   (a_ce),
    .ram_we_i   (a_we),
    .ram_addr_i (a_addr),
    .ram_sel_i  (a_sel),
    .ram_data_i (a_wdata),
    .data_o     (a_data),
    .ready_o    (a_ready),
    .stall_o    (a_stall)
`ifdef DMEM_ERR_EN
    ,
    .err_o      (a_err)
`endif
  );

  dmem_responder #(.ADDR_W(4), .WAIT_CYC(0), .BASE_ADDR(32'h0)) u_b (
    .clk        (clk),
    .rst        (rst),
    .ram_ce_i   (b_ce),
    .ram_we_i   (b_we),
    .ram_addr_i (b_addr),
    .ram_sel_i  (b_sel),
    .ram_data_i (b_wdata),
    .data_o     (b_data),
    .ready_o    (b_ready),
    .stall_o    (b_stall)
`ifdef DMEM_ERR_EN
    ,
    .err_o      (b_err)
`endif
  );

`ifndef DMEM_ERR_EN
  assign a_err = 1'b0;
  assign b_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One access on instance a; request fields are scrambled after acceptance to show capture.
  task automatic acc_a(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd,
                       output logic stall_seen, output logic er);
    @(negedge clk);
    a_ce = 1'b1; a_we = we; a_addr = addr; a_sel = sel; a_wdata = wd;
    lat = -1; rd = 32'h0; stall_seen = 1'b0; er = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        stall_seen = a_stall;
        a_addr = addr + 32'h4; a_sel = ~sel; a_wdata = ~wd;
      end
      if (a_ready) begin
        lat = i; rd = a_data; er = a_err;
        break;
      end
    end
    a_ce = 1'b0;
    @(posedge clk);
  endtask

  task automatic acc_b(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd,
                       output logic er);
    @(negedge clk);
    b_ce = 1'b1; b_we = we; b_addr = addr; b_sel = sel; b_wdata = wd;
    lat = -1; rd = 32'h0; er = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (b_ready) begin
        lat = i; rd = b_data; er = b_err;
        break;
      end
    end
    b_ce = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", a_ready); end
    checks++; if (a_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", a_data); end
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", a_stall); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready got=%b exp=0", b_ready); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] rd; logic st, er;
    acc_a(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat, rd, st, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL basic_wr_lat got=%0d exp=2", lat); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL basic_stall got=%b exp=1", st); end
    acc_a(1'b0, 32'h10, 4'hF, 32'h0, lat, rd, st, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL basic_rd_lat got=%0d exp=2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] rd; logic st, er;
    acc_a(1'b1, 32'h20, 4'hF, 32'h11223344, lat, rd, st, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lanes_pre_lat got=%0d exp=2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lanes_wr_hold got=%h exp=deadbeef", rd); end
    acc_a(1'b1, 32'h20, 4'h5, 32'hAABBCCDD, lat, rd, st, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lanes_wr_lat got=%0d exp=2", lat); end
    acc_a(1'b0, 32'h20, 4'hF, 32'h0, lat, rd, st, er);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL lanes_rd_f got=%h exp=11bb33dd", rd); end
    acc_a(1'b0, 32'h20, 4'h3, 32'h0, lat, rd, st, er);
    checks++; if (rd !== 32'h000033DD) begin errors++; $display("FAIL lanes_rd_3 got=%h exp=000033dd", rd); end
    acc_a(1'b1, 32'h20, 4'h0, 32'h0, lat, rd, st, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lanes_sel0_lat got=%0d exp=2", lat); end
    acc_a(1'b0, 32'h20, 4'hF, 32'h0, lat, rd, st, er);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL lanes_sel0_rd got=%h exp=11bb33dd", rd); end
  endtask

  task automatic test_abort();
    int lat; int pulses; logic [31:0] rd; logic st, er;
    acc_a(1'b1, 32'h30, 4'hF, 32'h0BADF00D, lat, rd, st, er);
    @(negedge clk);
    a_ce = 1'b1; a_we = 1'b1; a_addr = 32'h30; a_sel = 4'hF; a_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    a_ce = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (a_ready) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_ready got=%0d exp=0", pulses); end
    acc_a(1'b0, 32'h30, 4'hF, 32'h0, lat, rd, st, er);
    checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL abort_rd got=%h exp=0badf00d", rd); end
  endtask

  task automatic test_async_reset();
    int lat; logic [31:0] rd; logic st, er;
    acc_a(1'b1, 32'h34, 4'hF, 32'hCAFE0001, lat, rd, st, er);
    @(negedge clk);
    a_ce = 1'b1; a_we = 1'b1; a_addr = 32'h34; a_sel = 4'hF; a_wdata = 32'h0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL arst_ready got=%b exp=0", a_ready); end
    checks++; if (a_data !== 32'h0) begin errors++; $display("FAIL arst_data got=%h exp=0", a_data); end
    a_ce = 1'b0;
    @(negedge clk); rst = 1'b1;
    acc_a(1'b0, 32'h34, 4'hF, 32'h0, lat, rd, st, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL arst_lat got=%0d exp=2", lat); end
    checks++; if (rd !== 32'hCAFE0001) begin errors++; $display("FAIL arst_rd got=%h exp=cafe0001", rd); end
  endtask

`ifndef DMEM_ERR_EN
  task automatic test_wrap_nowait();
    int lat; logic [31:0] rd; logic er;
    acc_b(1'b1, 32'h40, 4'hF, 32'h5, lat, rd, er);
    checks++; if (lat !== 1) begin errors++; $display("FAIL wrap_wr_lat got=%0d exp=1", lat); end
    acc_b(1'b0, 32'h0, 4'hF, 32'h0, lat, rd, er);
    checks++; if (lat !== 1) begin errors++; $display("FAIL wrap_rd_lat got=%0d exp=1", lat); end
    checks++; if (rd !== 32'h5) begin errors++; $display("FAIL wrap_rd got=%h exp=00000005", rd); end
  endtask
`else
  task automatic test_err();
    int lat; logic [31:0] rd; logic er;
    acc_b(1'b1, 32'h4, 4'hF, 32'h77, lat, rd, er);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL err_ok_wr got=%b exp=0", er); end
    acc_b(1'b0, 32'h40, 4'hF, 32'h0, lat, rd, er);
    checks++; if (lat !== 1) begin errors++; $display("FAIL err_oor_lat got=%0d exp=1", lat); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_oor_err got=%b exp=1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_oor_data got=%h exp=0", rd); end
    acc_b(1'b1, 32'h4, 4'h0, 32'hFF, lat, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_sel0 got=%b exp=1", er); end
    acc_b(1'b0, 32'h4, 4'hF, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h77) begin errors++; $display("FAIL err_mem got=%h exp=00000077", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL err_ok_rd got=%b exp=0", er); end
  endtask
`endif

  initial begin
    rst = 1'b0;
    a_ce = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_sel = 4'h0; a_wdata = 32'h0;
    b_ce = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_sel = 4'h0; b_wdata = 32'h0;
    test_reset();
    test_basic();
    test_byte_lanes();
    test_abort();
    test_async_reset();
`ifndef DMEM_ERR_EN
    test_wrap_nowait();
`else
    test_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
